// File: rtl/usb_pkg.sv
// Shared USB definitions: PID codes, packet classes, CRC16 constants and the
// receive decoder state type.
package usb_pkg;

  typedef enum logic [3:0] {
    PID_OUT   = 4'h1,
    PID_IN    = 4'h9,
    PID_SOF   = 4'h5,
    PID_SETUP = 4'hD,
    PID_DATA0 = 4'h3,
    PID_DATA1 = 4'hB,
    PID_ACK   = 4'h2,
    PID_NAK   = 4'hA,
    PID_STALL = 4'hE
  } pid_e;

  localparam logic [1:0] CLS_SPECIAL = 2'b00;
  localparam logic [1:0] CLS_TOKEN   = 2'b01;
  localparam logic [1:0] CLS_HSK     = 2'b10;
  localparam logic [1:0] CLS_DATA    = 2'b11;

  localparam logic [15:0] CRC16_POLY_R = 16'hA001;
  localparam logic [15:0] CRC16_INIT   = 16'hFFFF;
  localparam logic [15:0] CRC16_RESID  = 16'hB001;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TOKEN,
    S_DATA,
    S_HSK,
    S_DISCARD,
    S_DONE
  } rx_state_e;

  // The upper nibble of a PID byte carries the complement of the lower nibble.
  function automatic logic pid_valid(input logic [7:0] pid_byte);
    return pid_byte[7:4] == ~pid_byte[3:0];
  endfunction

endpackage

// File: rtl/usb_crc16_byte.sv
// One-byte step of the reflected USB CRC16 (LSB first); shared by RX and TX.
module usb_crc16_byte
  import usb_pkg::*;
(
  input  logic [15:0] crc_i,
  input  logic [7:0]  byte_i,
  output logic [15:0] crc_o
);

  always_comb begin
    crc_o = crc_i;
    for (int i = 0; i < 8; i++) begin
      if (crc_o[0] ^ byte_i[i]) crc_o = (crc_o >> 1) ^ CRC16_POLY_R;
      else                      crc_o = crc_o >> 1;
    end
  end

endmodule

// File: rtl/usb_rx_packet_decoder.sv
// USB receive packet decoder: PID check, class decode, CRC16 on data packets,
// two-byte CRC holdback on the payload path and per-packet status.
//
// state     | meaning
// S_IDLE    | waiting for the PID byte of the next packet
// S_TOKEN   | token body: capture byte1/byte2, more bytes are a length error
// S_DATA    | data body: CRC16 and payload holdback/forwarding
// S_HSK     | handshake: any body byte is a length error
// S_DISCARD | bad or special PID, body ignored
// S_DONE    | one-cycle pkt_done with status registered
module usb_rx_packet_decoder
  import usb_pkg::*;
#(
  parameter  int MAX_PAYLOAD = 64,
  localparam int CW          = $clog2(MAX_PAYLOAD + 1)
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          new_byte,
  input  logic [7:0]    rx_byte,
  input  logic          rx_eop,
  output logic          pay_valid,
  output logic [7:0]    pay_byte,
  output logic          pkt_done,
  output logic [3:0]    pkt_pid,
  output logic          pkt_ok,
  output logic          err_pid,
  output logic          err_crc,
  output logic          err_len,
  output logic          err_ovf,
  output logic [CW-1:0] pay_count,
  output logic [10:0]   token_field
);

  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_PAYLOAD);

  rx_state_e     state_q, state_d, cls_st;
  logic [3:0]    pid_q, pid_d;
  logic          pid_err_q, pid_err_d;
  logic [15:0]   crc_q, crc_d, crc_nxt;
  logic [7:0]    buf0_q, buf0_d, buf1_q, buf1_d;
  logic [1:0]    buf_cnt_q, buf_cnt_d;
  logic [1:0]    body_q, body_d, body_inc;
  logic [CW-1:0] pay_cnt_q, pay_cnt_d;
  logic          ovf_q, ovf_d;
  logic [10:0]   tok_q, tok_d;

  logic          pay_valid_q, pay_valid_d;
  logic [7:0]    pay_byte_q, pay_byte_d;
  logic          pkt_done_q, pkt_done_d;
  logic [3:0]    pkt_pid_q, pkt_pid_d;
  logic          pkt_ok_q, pkt_ok_d;
  logic          err_pid_q, err_pid_d;
  logic          err_crc_q, err_crc_d;
  logic          err_len_q, err_len_d;
  logic          err_ovf_q, err_ovf_d;
  logic [CW-1:0] pay_count_q, pay_count_d;
  logic [10:0]   token_field_q, token_field_d;

  usb_crc16_byte u_crc (
    .crc_i  (crc_q),
    .byte_i (rx_byte),
    .crc_o  (crc_nxt)
  );

  // Body length only matters up to "more than two", so it saturates at 3.
  assign body_inc = (body_q == 2'd3) ? body_q : body_q + 2'd1;

  always_comb begin
    state_d       = state_q;
    pid_d         = pid_q;
    pid_err_d     = pid_err_q;
    crc_d         = crc_q;
    buf0_d        = buf0_q;
    buf1_d        = buf1_q;
    buf_cnt_d     = buf_cnt_q;
    body_d        = body_q;
    pay_cnt_d     = pay_cnt_q;
    ovf_d         = ovf_q;
    tok_d         = tok_q;
    pay_valid_d   = 1'b0;
    pay_byte_d    = pay_byte_q;
    pkt_done_d    = 1'b0;
    pkt_pid_d     = pkt_pid_q;
    pkt_ok_d      = pkt_ok_q;
    err_pid_d     = err_pid_q;
    err_crc_d     = err_crc_q;
    err_len_d     = err_len_q;
    err_ovf_d     = err_ovf_q;
    pay_count_d   = pay_count_q;
    token_field_d = token_field_q;
    cls_st        = S_IDLE;

    case (state_q)
      S_IDLE: if (new_byte) begin
        pid_d     = rx_byte[3:0];
        pid_err_d = !pid_valid(rx_byte);
        crc_d     = CRC16_INIT;
        buf_cnt_d = 2'd0;
        body_d    = 2'd0;
        pay_cnt_d = '0;
        ovf_d     = 1'b0;
        tok_d     = '0;
        if (!pid_valid(rx_byte)) state_d = S_DISCARD;
        else begin
          case (rx_byte[1:0])
            CLS_TOKEN: state_d = S_TOKEN;
            CLS_DATA:  state_d = S_DATA;
            CLS_HSK:   state_d = S_HSK;
            default:   state_d = S_DISCARD;
          endcase
        end
      end
      S_TOKEN: if (new_byte) begin
        if (body_q == 2'd0)      tok_d[7:0]  = rx_byte;
        else if (body_q == 2'd1) tok_d[10:8] = rx_byte[2:0];
        body_d = body_inc;
      end
      S_DATA: if (new_byte) begin
        crc_d  = crc_nxt;
        body_d = body_inc;
        case (buf_cnt_q)
          2'd0: begin
            buf0_d    = rx_byte;
            buf_cnt_d = 2'd1;
          end
          2'd1: begin
            buf1_d    = rx_byte;
            buf_cnt_d = 2'd2;
          end
          default: begin
            // Buffer full: the oldest byte is known not to be CRC.
            if (pay_cnt_q < MAX_CNT) begin
              pay_valid_d = 1'b1;
              pay_byte_d  = buf0_q;
              pay_cnt_d   = pay_cnt_q + CW'(1);
            end else begin
              ovf_d = 1'b1;
            end
            buf0_d = buf1_q;
            buf1_d = rx_byte;
          end
        endcase
      end
      S_HSK: if (new_byte) body_d = body_inc;
      S_DONE: state_d = S_IDLE;
      default: ;
    endcase

    // A byte arriving with rx_eop has already been folded into the _d values.
    if (rx_eop && state_q != S_DONE && (state_q != S_IDLE || new_byte)) begin
      cls_st      = state_d;
      state_d     = S_DONE;
      pkt_done_d  = 1'b1;
      pkt_pid_d   = pid_d;
      err_pid_d   = pid_err_d;
      err_crc_d   = 1'b0;
      err_len_d   = 1'b0;
      err_ovf_d   = 1'b0;
      pay_count_d = '0;
      case (cls_st)
        S_TOKEN: begin
          err_len_d     = (body_d != 2'd2);
          token_field_d = tok_d;
        end
        S_DATA: begin
          err_len_d   = (body_d < 2'd2);
          err_crc_d   = (crc_d != CRC16_RESID);
          err_ovf_d   = ovf_d;
          pay_count_d = pay_cnt_d;
        end
        S_HSK:   err_len_d = (body_d != 2'd0);
        default: ;
      endcase
      pkt_ok_d = ~(err_pid_d | err_crc_d | err_len_d | err_ovf_d);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= S_IDLE;
      pid_q         <= '0;
      pid_err_q     <= 1'b0;
      crc_q         <= CRC16_INIT;
      buf0_q        <= '0;
      buf1_q        <= '0;
      buf_cnt_q     <= 2'd0;
      body_q        <= 2'd0;
      pay_cnt_q     <= '0;
      ovf_q         <= 1'b0;
      tok_q         <= '0;
      pay_valid_q   <= 1'b0;
      pay_byte_q    <= '0;
      pkt_done_q    <= 1'b0;
      pkt_pid_q     <= '0;
      pkt_ok_q      <= 1'b0;
      err_pid_q     <= 1'b0;
      err_crc_q     <= 1'b0;
      err_len_q     <= 1'b0;
      err_ovf_q     <= 1'b0;
      pay_count_q   <= '0;
      token_field_q <= '0;
    end else begin
      state_q       <= state_d;
      pid_q         <= pid_d;
      pid_err_q     <= pid_err_d;
      crc_q         <= crc_d;
      buf0_q        <= buf0_d;
      buf1_q        <= buf1_d;
      buf_cnt_q     <= buf_cnt_d;
      body_q        <= body_d;
      pay_cnt_q     <= pay_cnt_d;
      ovf_q         <= ovf_d;
      tok_q         <= tok_d;
      pay_valid_q   <= pay_valid_d;
      pay_byte_q    <= pay_byte_d;
      pkt_done_q    <= pkt_done_d;
      pkt_pid_q     <= pkt_pid_d;
      pkt_ok_q      <= pkt_ok_d;
      err_pid_q     <= err_pid_d;
      err_crc_q     <= err_crc_d;
      err_len_q     <= err_len_d;
      err_ovf_q     <= err_ovf_d;
      pay_count_q   <= pay_count_d;
      token_field_q <= token_field_d;
    end
  end

  assign pay_valid   = pay_valid_q;
  assign pay_byte    = pay_byte_q;
  assign pkt_done    = pkt_done_q;
  assign pkt_pid     = pkt_pid_q;
  assign pkt_ok      = pkt_ok_q;
  assign err_pid     = err_pid_q;
  assign err_crc     = err_crc_q;
  assign err_len     = err_len_q;
  assign err_ovf     = err_ovf_q;
  assign pay_count   = pay_count_q;
  assign token_field = token_field_q;

endmodule
